// File: rtl/bitfield_pkg.sv
// Shared widths and helpers for the LSB-first bitfield extractor.
// The word width is fixed at 16 and the accumulator holds exactly two words.
package bitfield_pkg;
    localparam int WORD_W = 16;
    localparam int BUF_W  = 32;
    localparam int CNT_W  = 6;

    // rd_len encodes length-1, so the all-ones mask is shifted down by (15 - len).
    function automatic logic [WORD_W-1:0] len_mask(input logic [3:0] len);
        return {WORD_W{1'b1}} >> (4'd15 - len);
    endfunction

    function automatic logic [4:0] fld_len(input logic [3:0] len);
        return {1'b0, len} + 5'd1;
    endfunction
endpackage

// File: rtl/bitfield_reader_bit_accum.sv
// Bit accumulator: holds valid bits in acc_q[cnt_q-1:0] and does the
// combined shift-out / append, plus word alignment and flush.
module bit_accum
    import bitfield_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              align_i,
    input  logic              rd_fire_i,
    input  logic [3:0]        rd_len_i,
    input  logic              wr_fire_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [WORD_W-1:0] fld_o,
    output logic [CNT_W-1:0]  cnt_o
);
    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       shamt;
    logic [CNT_W-1:0] base;

    // Bits above cnt_q are kept zero, so appends can simply OR in the new word.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        shamt = rd_fire_i ? fld_len(rd_len_i) : 5'd0;
        base  = cnt_q - {1'b0, shamt};
        if (flush_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (align_i) begin
            acc_d = acc_q >> cnt_q[3:0];
            cnt_d = cnt_q & 6'b110000;
        end else begin
            acc_d = acc_q >> shamt;
            cnt_d = base;
            if (wr_fire_i) begin
                acc_d = acc_d | ({{(BUF_W-WORD_W){1'b0}}, wr_data_i} << base);
                cnt_d = base + CNT_W'(WORD_W);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign fld_o = acc_q[WORD_W-1:0] & len_mask(rd_len_i);
    assign cnt_o = cnt_q;
endmodule

// File: rtl/bitfield_reader.sv
// Variable-length LSB-first field extractor over a 16-bit word stream.
// Handshakes and the registered field output live here; bit storage in bit_accum.
module bitfield_reader
    import bitfield_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              align,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        rd_len,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic [WORD_W-1:0] fld_data,
    output logic              fld_valid,
    input  logic              fld_ready,
    output logic [CNT_W-1:0]  bits_avail
);
    logic [WORD_W-1:0] fld_data_q, fld_data_d;
    logic              fld_valid_q, fld_valid_d;
    logic [WORD_W-1:0] fld_w;
    logic [CNT_W-1:0]  cnt;
    logic              rd_fire, wr_fire, quiet;

    // Ready terms use registered occupancy only; reset_n gating keeps them low in reset.
    assign quiet    = reset_n && !flush && !align;
    assign in_ready = quiet && (cnt <= CNT_W'(WORD_W));
    assign rd_ready = quiet && (cnt >= {1'b0, fld_len(rd_len)}) && (!fld_valid_q || fld_ready);
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_fire  = in_valid && in_ready;

    bit_accum u_accum (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (flush),
        .align_i   (align),
        .rd_fire_i (rd_fire),
        .rd_len_i  (rd_len),
        .wr_fire_i (wr_fire),
        .wr_data_i (in_data),
        .fld_o     (fld_w),
        .cnt_o     (cnt)
    );

    always_comb begin
        fld_data_d  = fld_data_q;
        fld_valid_d = fld_valid_q;
        if (flush) begin
            fld_valid_d = 1'b0;
        end else if (rd_fire) begin
            fld_data_d  = fld_w;
            fld_valid_d = 1'b1;
        end else if (fld_ready) begin
            fld_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fld_data_q  <= '0;
            fld_valid_q <= 1'b0;
        end else begin
            fld_data_q  <= fld_data_d;
            fld_valid_q <= fld_valid_d;
        end
    end

    assign fld_data   = fld_data_q;
    assign fld_valid  = fld_valid_q;
    assign bits_avail = cnt;
endmodule

// File: tb/tb_bitfield_reader.sv
// Bench for bitfield_reader: bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bitfield_reader;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        flush = 0, align = 0;
    logic [15:0] in_data = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [3:0]  rd_len = 0;
    logic        rd_valid = 0;
    logic        rd_ready;
    logic [15:0] fld_data;
    logic        fld_valid;
    logic        fld_ready = 1;
    logic [5:0]  bits_avail;

    int checks = 0;
    int passes = 0;

    bitfield_reader dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .align(align),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rd_len(rd_len), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fld_data(fld_data), .fld_valid(fld_valid), .fld_ready(fld_ready),
        .bits_avail(bits_avail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic timeout(input string nm);
        checks++;
        $display("FAIL %s: handshake never happened at %0t", nm, $time);
    endtask

    // Reference model: the buffer is just a queue of bits, front = next to read.
    bit          mq[$];
    bit          m_fv = 0;
    logic [15:0] m_fd = 0;
    int          m_len;
    logic [15:0] m_f;
    bit          m_ir, m_rr;

    always @(negedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_fv = 0;
            chk("rst_in_ready", {31'b0, in_ready}, 0);
            chk("rst_rd_ready", {31'b0, rd_ready}, 0);
            chk("rst_fld_valid", {31'b0, fld_valid}, 0);
            chk("rst_fld_data", {16'b0, fld_data}, 0);
            chk("rst_bits_avail", {26'b0, bits_avail}, 0);
        end else begin
            m_len = int'(rd_len) + 1;
            m_ir = (mq.size() <= 16) && !flush && !align;
            m_rr = (mq.size() >= m_len) && (!m_fv || fld_ready) && !flush && !align;
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_ir});
            chk("rd_ready", {31'b0, rd_ready}, {31'b0, m_rr});
            chk("bits_avail", {26'b0, bits_avail}, mq.size());
            chk("fld_valid", {31'b0, fld_valid}, {31'b0, m_fv});
            if (m_fv) chk("fld_data", {16'b0, fld_data}, {16'b0, m_fd});
            if (flush) begin
                mq.delete();
                m_fv = 0;
            end else if (align) begin
                repeat (mq.size() % 16) void'(mq.pop_front());
                if (fld_ready) m_fv = 0;
            end else begin
                if (rd_valid && m_rr) begin
                    m_f = 0;
                    for (int i = 0; i < m_len; i++) m_f[i] = mq.pop_front();
                    m_fd = m_f;
                    m_fv = 1;
                end else if (fld_ready) m_fv = 0;
                if (in_valid && m_ir)
                    for (int i = 0; i < 16; i++) mq.push_back(in_data[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] w);
        bit ok = 0;
        in_valid = 1; in_data = w;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!ok) timeout("push");
    endtask

    task automatic rd(input logic [3:0] len);
        bit ok = 0;
        rd_valid = 1; rd_len = len;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (rd_ready) ok = 1;
            @(posedge clk); #1;
        end
        rd_valid = 0;
        if (!ok) timeout("rd");
    endtask

    task automatic pulse_flush();
        flush = 1; step(); flush = 0;
    endtask

    initial begin
        repeat (3) step();
        chk("reset_in_ready_low", {31'b0, in_ready}, 0);
        reset_n = 1;
        step();

        // 1: sequential fields from one word
        push(16'hA5C3);
        rd(3);  chk("t1_f0", {16'b0, fld_data}, 32'h003);
        rd(7);  chk("t1_f1", {16'b0, fld_data}, 32'h05C);
        rd(3);  chk("t1_f2", {16'b0, fld_data}, 32'h00A);
        chk("t1_bits", {26'b0, bits_avail}, 0);

        // 2: straddling field
        push(16'h00FF); push(16'h1234);
        rd(11); chk("t2_f0", {16'b0, fld_data}, 32'h0FF);
        rd(7);  chk("t2_f1", {16'b0, fld_data}, 32'h040);
        chk("t2_bits", {26'b0, bits_avail}, 12);

        // 3: output backpressure
        pulse_flush();
        push(16'hA5C3);
        fld_ready = 0;
        rd(3); chk("t3_f0", {16'b0, fld_data}, 32'h003);
        rd_valid = 1; rd_len = 3;
        repeat (3) begin
            @(negedge clk);
            chk("t3_rd_blocked", {31'b0, rd_ready}, 0);
            chk("t3_hold", {16'b0, fld_data}, 32'h003);
            step();
        end
        fld_ready = 1;
        @(negedge clk); chk("t3_rd_open", {31'b0, rd_ready}, 1);
        step(); rd_valid = 0;
        chk("t3_f1", {16'b0, fld_data}, 32'h00C);
        chk("t3_v1", {31'b0, fld_valid}, 1);

        // 4: full buffer
        pulse_flush();
        push(16'h1111); push(16'h2222);
        in_valid = 1; in_data = 16'h3333;
        @(negedge clk);
        chk("t4_stall", {31'b0, in_ready}, 0);
        chk("t4_full", {26'b0, bits_avail}, 32);
        step();
        rd_valid = 1; rd_len = 15;
        @(negedge clk); chk("t4_rd_ok", {31'b0, rd_ready}, 1);
        step(); rd_valid = 0;
        chk("t4_f0", {16'b0, fld_data}, 32'h1111);
        chk("t4_in_ready_back", {31'b0, in_ready}, 1);
        step(); in_valid = 0;
        chk("t4_refull", {26'b0, bits_avail}, 32);
        rd(15); chk("t4_f1", {16'b0, fld_data}, 32'h2222);
        rd(15); chk("t4_f2", {16'b0, fld_data}, 32'h3333);

        // 5: align
        pulse_flush();
        push(16'hFFFF); push(16'h0001);
        rd(2); chk("t5_f0", {16'b0, fld_data}, 32'h007);
        align = 1; step(); align = 0;
        chk("t5_bits", {26'b0, bits_avail}, 16);
        rd(15); chk("t5_f1", {16'b0, fld_data}, 32'h0001);

        // 6: flush with pending field, then reset mid-handshake
        pulse_flush();
        push(16'hABCD); push(16'h1234);
        fld_ready = 0;
        rd(11); chk("t6_f0", {16'b0, fld_data}, 32'hBCD);
        chk("t6_bits20", {26'b0, bits_avail}, 20);
        pulse_flush();
        chk("t6_flush_bits", {26'b0, bits_avail}, 0);
        chk("t6_flush_fv", {31'b0, fld_valid}, 0);
        fld_ready = 1;
        push(16'h5555);
        rd(0);
        rd_valid = 1; rd_len = 3;
        @(negedge clk);
        chk("t6_rd_pending", {31'b0, rd_ready}, 1);
        #1 reset_n = 0;
        #1;
        chk("t6_rst_fv", {31'b0, fld_valid}, 0);
        chk("t6_rst_fd", {16'b0, fld_data}, 0);
        chk("t6_rst_bits", {26'b0, bits_avail}, 0);
        chk("t6_rst_rr", {31'b0, rd_ready}, 0);
        chk("t6_rst_ir", {31'b0, in_ready}, 0);
        rd_valid = 0;
        repeat (2) step();
        reset_n = 1;
        step();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            rd_valid  = ($urandom_range(0, 3) != 0);
            rd_len    = 4'($urandom_range(0, 15));
            fld_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            align     = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid = 0; rd_valid = 0; flush = 0; align = 0; fld_ready = 1;
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
